load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the control unit, between the datapath and a word-wide data memory bus with a request/acknowledge handshake. It turns MemRead/MemWrite/DataWidth plus the ALU-computed address into aligned bus transactions with byte enables. It stalls the pipeline while a transaction is outstanding. It formats load data, selecting the byte lane and applying sign or zero extension, before the result goes to the write-back mux.

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns MemRead/MemWrite requests into aligned
// request/ack bus transactions, stalls the pipeline meanwhile and formats load data.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            DataWidth,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [31:0]           WriteData,
    output logic [31:0]           ReadData,
    output logic                  Stall,
    output logic                  Misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  fmt_half_q, fmt_half_d;
    logic                  fmt_byte_q, fmt_byte_d;
    logic                  fmt_uns_q, fmt_uns_d;
    logic [1:0]            fmt_off_q, fmt_off_d;

    logic                  req;
    logic                  is_half;
    logic                  is_byte;
    logic [1:0]            off;
    logic                  misal;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_fmt;

    // Request decode: unlisted width codes fall back to word accesses.
    always_comb begin
        req     = MemRead | MemWrite;
        is_half = (DataWidth[1:0] == 2'b01);
        is_byte = (DataWidth[1:0] == 2'b10);
        off     = ALUResult[1:0];
        if (is_byte) begin
            misal      = 1'b0;
            lane_be    = 4'(4'b0001 << off);
            lane_wdata = {4{WriteData[7:0]}};
        end else if (is_half) begin
            misal      = off[0];
            lane_be    = 4'(4'b0011 << off);
            lane_wdata = {2{WriteData[15:0]}};
        end else begin
            misal      = (off != 2'b00);
            lane_be    = 4'b1111;
            lane_wdata = WriteData;
        end
    end

    // Load formatting from the registered width/offset of the outstanding access.
    always_comb begin
        case (fmt_off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = fmt_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (fmt_byte_q) begin
            ld_fmt = {{24{~fmt_uns_q & ld_byte[7]}}, ld_byte};
        end else if (fmt_half_q) begin
            ld_fmt = {{16{~fmt_uns_q & ld_half[15]}}, ld_half};
        end else begin
            ld_fmt = mem_rdata;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        read_data_d = read_data_q;
        fmt_half_d  = fmt_half_q;
        fmt_byte_d  = fmt_byte_q;
        fmt_uns_d   = fmt_uns_q;
        fmt_off_d   = fmt_off_q;
        Stall       = 1'b0;
        Misaligned  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (misal) begin
                        Misaligned = 1'b1;
                    end else begin
                        Stall       = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                        mem_be_d    = lane_be;
                        mem_wdata_d = lane_wdata;
                        fmt_half_d  = is_half;
                        fmt_byte_d  = is_byte;
                        fmt_uns_d   = DataWidth[2];
                        fmt_off_d   = off;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                Stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (!mem_we_q) begin
                        read_data_d = ld_fmt;
                    end
                end
            end
            DONE: begin
                // Inputs still show the completed instruction; one free cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            read_data_q <= 32'h0;
            fmt_half_q  <= 1'b0;
            fmt_byte_q  <= 1'b0;
            fmt_uns_q   <= 1'b0;
            fmt_off_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            read_data_q <= read_data_d;
            fmt_half_q  <= fmt_half_d;
            fmt_byte_q  <= fmt_byte_d;
            fmt_uns_q   <= fmt_uns_d;
            fmt_off_q   <= fmt_off_d;
        end
    end

    assign ReadData  = read_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs driven and outputs sampled around the falling edge.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  DataWidth;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    int          obs_stall;
    int          obs_busy;
    logic        obs_done;
    logic        obs_stable;
    logic        obs_first_stall;
    logic        obs_first_req;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [31:0] obs_rd;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .DataWidth(DataWidth), .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Misaligned(Misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one access starting at the next falling edge, acks after wait_cyc BUSY cycles,
    // and records what the bus and pipeline outputs did until DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] dw,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int wait_cyc);
        obs_stall  = 0;
        obs_busy   = 0;
        obs_done   = 1'b0;
        obs_stable = 1'b1;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; DataWidth = dw; ALUResult = addr; WriteData = wd;
        #1;
        obs_first_stall = Stall;
        obs_first_req   = mem_req;
        for (int c = 0; c < 40 && !obs_done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            if (Stall) obs_stall++;
            if (mem_req) begin
                if (obs_busy == 0) begin
                    obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we; obs_addr = mem_addr;
                end else if (mem_be !== obs_be || mem_wdata !== obs_wdata ||
                             mem_we !== obs_we || mem_addr !== obs_addr) begin
                    obs_stable = 1'b0;
                end
                obs_busy++;
                if (obs_busy == wait_cyc + 1) begin
                    mem_ack = 1'b1; mem_rdata = rdat;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 32'h0;
                end
            end else if (obs_busy > 0) begin
                mem_ack  = 1'b0;
                obs_rd   = ReadData;
                obs_done = 1'b1;
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        MemRead = 0; MemWrite = 0; DataWidth = 3'b000; ALUResult = 32'h0;
        WriteData = 32'h0; mem_ack = 0; mem_rdata = 32'h0;
        #12;
        checks++;
        if ({mem_req, mem_we, mem_be, Stall, Misaligned} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b we=%b be=%b stall=%b mis=%b want all 0",
                     mem_req, mem_we, mem_be, Stall, Misaligned);
        end
        checks++;
        if ({mem_addr, mem_wdata, ReadData} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got addr=%h wdata=%h rd=%h want 0", mem_addr, mem_wdata, ReadData);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lw_basic();
        run_access(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        checks++;
        if (obs_done !== 1'b1) begin errors++; $display("FAIL lw_done got %b want 1", obs_done); end
        checks++;
        if ({obs_addr, obs_be, obs_we} !== {32'h100, 4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL lw_bus got addr=%h be=%b we=%b want 100 1111 0", obs_addr, obs_be, obs_we);
        end
        checks++;
        if (obs_stall !== 2) begin errors++; $display("FAIL lw_stall got %0d want 2", obs_stall); end
        checks++;
        if (obs_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", obs_rd); end
    endtask

    task automatic test_load_format();
        logic [2:0]  dw  [5] = '{3'b010, 3'b110, 3'b101, 3'b001, 3'b010};
        logic [31:0] ad  [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
        logic [31:0] exd [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFF8012, 32'h00000034};
        logic [3:0]  exb [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b1, 1'b0, dw[i], ad[i], 32'h0, 32'h80123456, 0);
            checks++;
            if (obs_rd !== exd[i] || obs_done !== 1'b1) begin
                errors++;
                $display("FAIL load_fmt%0d got %h done=%b want %h", i, obs_rd, obs_done, exd[i]);
            end
            checks++;
            if (obs_be !== exb[i] || obs_addr !== 32'h100) begin
                errors++;
                $display("FAIL load_lanes%0d got be=%b addr=%h want %b 100", i, obs_be, obs_addr, exb[i]);
            end
        end
    endtask

    task automatic test_store_half();
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0);
        checks++;
        if ({obs_be, obs_wdata, obs_we} !== {4'b1100, 32'hABCDABCD, 1'b1}) begin
            errors++;
            $display("FAIL sh_bus got be=%b wdata=%h we=%b want 1100 abcdabcd 1", obs_be, obs_wdata, obs_we);
        end
        checks++;
        if (obs_rd !== 32'h00000034) begin errors++; $display("FAIL sh_rd_hold got %h want 00000034", obs_rd); end
        run_access(1'b0, 1'b1, 3'b110, 32'h201, 32'h000000A5, 32'h0, 0);
        checks++;
        if ({obs_be, obs_wdata, obs_addr} !== {4'b0010, 32'hA5A5A5A5, 32'h200}) begin
            errors++;
            $display("FAIL sb_bus got be=%b wdata=%h addr=%h want 0010 a5a5a5a5 200", obs_be, obs_wdata, obs_addr);
        end
    endtask

    task automatic test_store_wait();
        run_access(1'b0, 1'b1, 3'b000, 32'h200, 32'hCAFEF00D, 32'h0, 3);
        checks++;
        if (obs_busy !== 4 || obs_stable !== 1'b1) begin
            errors++;
            $display("FAIL sw_busy got cycles=%0d stable=%b want 4 1", obs_busy, obs_stable);
        end
        checks++;
        if (obs_stall !== 5) begin errors++; $display("FAIL sw_stall got %0d want 5", obs_stall); end
        checks++;
        if ({obs_be, obs_wdata, obs_we, obs_addr} !== {4'b1111, 32'hCAFEF00D, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL sw_bus got be=%b wdata=%h we=%b addr=%h", obs_be, obs_wdata, obs_we, obs_addr);
        end
    endtask

    task automatic test_back_to_back();
        // A load issued right after DONE must see IDLE immediately (single DONE cycle).
        run_access(1'b1, 1'b0, 3'b000, 32'h108, 32'h0, 32'h11223344, 0);
        checks++;
        if (obs_first_stall !== 1'b1 || obs_rd !== 32'h11223344) begin
            errors++;
            $display("FAIL b2b got first_stall=%b rd=%h want 1 11223344", obs_first_stall, obs_rd);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        MemRead = 1'b1; DataWidth = 3'b000; ALUResult = 32'h101;
        #1;
        checks++;
        if ({Misaligned, Stall, mem_req} !== 3'b100) begin
            errors++;
            $display("FAIL mis_lw got mis=%b stall=%b req=%b want 1 0 0", Misaligned, Stall, mem_req);
        end
        run_access(1'b1, 1'b0, 3'b000, 32'h104, 32'h0, 32'h0F0F0F0F, 0);
        checks++;
        if (obs_first_req !== 1'b0 || obs_rd !== 32'h0F0F0F0F || obs_addr !== 32'h104) begin
            errors++;
            $display("FAIL mis_next got req=%b rd=%h addr=%h want 0 0f0f0f0f 104", obs_first_req, obs_rd, obs_addr);
        end
        @(negedge clk);
        MemWrite = 1'b1; DataWidth = 3'b101; ALUResult = 32'h203;
        #1;
        checks++;
        if ({Misaligned, Stall} !== 2'b10) begin
            errors++;
            $display("FAIL mis_sh got mis=%b stall=%b want 1 0", Misaligned, Stall);
        end
        MemWrite = 1'b0;
    endtask

    task automatic test_idle_ack();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        #1;
        checks++;
        if ({Stall, Misaligned, mem_req} !== 3'b000 || mem_addr !== 32'h104) begin
            errors++;
            $display("FAIL idle_outputs got stall=%b mis=%b req=%b addr=%h", Stall, Misaligned, mem_req, mem_addr);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if (ReadData !== 32'h0F0F0F0F || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack got rd=%h req=%b want 0f0f0f0f 0", ReadData, mem_req);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        MemRead = 1'b1; DataWidth = 3'b000; ALUResult = 32'h300;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre got req=%b want 1", mem_req); end
        #1;
        rst_n = 1'b0; MemRead = 1'b0;
        #1;
        checks++;
        if ({mem_req, Stall} !== 2'b00 || ReadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy got req=%b stall=%b rd=%h want 0 0 0", mem_req, Stall, ReadData);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_req, Stall} !== 2'b00 || ReadData !== 32'h0) begin
            errors++;
            $display("FAIL rst_stale_ack got req=%b stall=%b rd=%h want 0 0 0", mem_req, Stall, ReadData);
        end
        run_access(1'b1, 1'b0, 3'b000, 32'h104, 32'h0, 32'h0BADF00D, 1);
        checks++;
        if (obs_rd !== 32'h0BADF00D || obs_stall !== 3) begin
            errors++;
            $display("FAIL rst_recover got rd=%h stall=%0d want 0badf00d 3", obs_rd, obs_stall);
        end
    endtask

    initial begin
        test_reset();
        test_lw_basic();
        test_load_format();
        test_store_half();
        test_store_wait();
        test_back_to_back();
        test_misaligned();
        test_idle_ack();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
